load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly upstream of memory_stage, between execute and memory.
- Accepts byte-addressed load/store requests from execute over a valid/ready handshake.
- Converts each request into word-indexed accesses on the single-port word memory. Sub-word stores use read-modify-write.
- Returns aligned, sign/zero-extended load data plus an error flag to writeback over a second valid/ready handshake.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words behind memory_stage; used only by the bounds check.
- RD_W, 5, width of the destination-register tag carried from request to response.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  execute presents a request
- req_ready  output  1  block can accept a request; high only in IDLE
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- req_rd  input  RD_W  destination tag
- resp_valid  output  1  response available
- resp_ready  input  1  writeback accepts the response
- resp_data  output  32  extended load data; 0 for stores and errors
- resp_rd  output  RD_W  tag of the completed request
- resp_err  output  1  misaligned, reserved size, or out of bounds
- mem_addr  output  32  word index to memory_stage, {2'b00, addr[31:2]}
- mem_wdata  output  32  full-word write data
- mem_we  output  1  write enable, high exactly one cycle per write
- mem_rdata  input  32  registered read data from memory_stage

Behaviour:
- All outputs are registered. On reset, every output is 0 except req_ready = 1, and state = IDLE. Reset is asynchronous: it aborts any operation in flight, drops mem_we the same instant, and discards the pending response.
- States: IDLE, RD, CAP, WR, RESP.
- Accept: req_valid && req_ready at edge E0. Latch addr, wdata, size, unsigned, rd, we.
- Error check at accept:
  - size 11 → error.
  - half with addr[0] = 1 → error.
  - word with addr[1:0] ≠ 0 → error.
  - On error: go to RESP with resp_err = 1 and resp_data = 0. mem_we is never asserted.
- Word store: IDLE → WR, with mem_we = 1 and mem_wdata = req_wdata. Next edge → RESP. resp_valid rises 2 cycles after accept.
- Load: IDLE → RD (mem_addr driven, mem_we = 0) → CAP. At the CAP edge, capture mem_rdata and go to RESP. resp_valid rises 3 cycles after accept.
- Sub-word store (byte or half): IDLE → RD → CAP. In CAP, merge the old word with new data in the lanes selected by addr[1:0], then go to WR with mem_we = 1 and mem_wdata = merged word, then RESP. resp_valid rises 4 cycles after accept. Unselected lanes keep their old values.
- Lane rules (little-endian):
  - byte lane = addr[1:0].
  - half lane = addr[1]; bits [15:0] when addr[1] = 0, bits [31:16] when addr[1] = 1.
  - Load extension uses bit 7 or bit 15 of the extracted field unless req_unsigned = 1.
- RESP: resp_valid held high and resp_data/resp_rd/resp_err held stable until resp_ready. Leave RESP on the edge where resp_ready = 1; return to IDLE, and req_ready rises the following cycle. No request is accepted in the same cycle as a response handshake.
- mem_addr keeps its last value outside RD/WR. Reads issued from IDLE are harmless.
- mem_we is 0 in every state except WR.
- resp_ready asserted outside RESP is ignored. Request fields are ignored unless req_ready is high.

Optional Feature:
- Macro LSU_BOUNDS_CHECK_EN.
- When defined: at accept, a word index (addr[31:2]) ≥ DEPTH_WORDS is treated as an error, with the same path as misalignment (RESP, resp_err = 1, no memory access).
- When undefined: no range check is made. The upper index bits are passed through unchanged and only alignment/size errors set resp_err.

Test Plan:
- Word store then load: store addr 0x10, data 0xDEADBEEF → mem_we high one cycle with mem_addr = 4, resp 2 cycles after accept; load word at 0x10 → resp_data 0xDEADBEEF, 3 cycles after accept.
- Signed/unsigned byte: memory word 4 = 0x80FF7F01; lb 0x13 → 0xFFFFFF80; lbu 0x13 → 0x00000080; lb 0x11 → 0x0000007F.
- Sub-word store RMW: word 4 = 0x11223344; sh 0x12 with data 0xAAAA → write of 0xAAAA3344, resp 4 cycles after accept, mem_we high exactly one cycle.
- Errors: lw 0x13, sh 0x11, and size 11 → resp_err = 1, resp_data = 0, mem_we never asserted, resp 1 cycle after accept. With LSU_BOUNDS_CHECK_EN, lw 0x1000 → resp_err = 1.
- Backpressure: hold resp_ready = 0 for 5 cycles after a load → resp_valid and resp_data stay stable and req_ready stays 0; release → IDLE next cycle, then the next request is accepted.
- Reset mid-op: assert rst during WR of a sub-word store → mem_we drops immediately, resp_valid = 0, req_ready = 1, and no response is produced after release.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Byte-addressed load/store front end for a single-port, 32-bit
//             word memory with a registered read. Word stores go straight to
//             a write; loads read, capture and extend; byte/half stores use
//             read-modify-write. Misaligned, reserved-size and (optionally)
//             out-of-range requests complete with an error and no memory
//             access.
//  Ports    : clk, rst                  clock, async active-high reset
//             req_*                     request channel from execute
//                                       (valid/ready, addr, wdata, we, size,
//                                       unsigned, rd tag)
//             resp_*                    response channel to writeback
//                                       (valid/ready, data, rd tag, err)
//             mem_addr/mem_wdata/mem_we word-indexed memory request
//             mem_rdata                 registered read data from memory
//  Options  : LSU_BOUNDS_CHECK_EN - when defined, a word index at or above
//             DEPTH_WORDS is reported as an error instead of being accessed.
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
   parameter int DEPTH_WORDS = 1024,
   parameter int RD_W        = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [31:0]     req_addr,
   input  logic [31:0]     req_wdata,
   input  logic            req_we,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [RD_W-1:0] req_rd,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [31:0]     resp_data,
   output logic [RD_W-1:0] resp_rd,
   output logic            resp_err,
   output logic [31:0]     mem_addr,
   output logic [31:0]     mem_wdata,
   output logic            mem_we,
   input  logic [31:0]     mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CAP  = 3'd2,
      S_WR   = 3'd3,
      S_RESP = 3'd4
   } state_t;

   generate
      if (DEPTH_WORDS < 1) begin : g_depth_check
         $error("load_store_unit: DEPTH_WORDS must be at least 1");
      end
   endgenerate

   state_t      r_state;
   logic [1:0]  r_off;       // byte offset inside the word
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic        r_we;
   logic [15:0] r_wdata;     // only sub-word stores need the data after accept

   logic        w_accept;
   logic        w_misalign;
   logic        w_oob;
   logic        w_err;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_merged;

   assign w_accept   = req_valid && req_ready;
   assign w_misalign = (req_size == 2'b11) ||
                       ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef LSU_BOUNDS_CHECK_EN
   // Extra top bit so a depth of exactly 2^30 words still compares correctly.
   localparam logic [30:0] c_depth_idx = 31'(DEPTH_WORDS);
   assign w_oob = ({1'b0, req_addr[31:2]} >= c_depth_idx);
`else
   assign w_oob = 1'b0;
`endif

   assign w_err = w_misalign || w_oob;

   // Lane extraction for loads and lane merge for sub-word stores, both
   // working on the word read back from memory during CAP.
   always_comb begin
      w_byte = mem_rdata[7:0];
      case (r_off)
         2'd0:    w_byte = mem_rdata[7:0];
         2'd1:    w_byte = mem_rdata[15:8];
         2'd2:    w_byte = mem_rdata[23:16];
         default: w_byte = mem_rdata[31:24];
      endcase
      w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

      case (r_size)
         2'b00:   w_load = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
         2'b01:   w_load = {{16{w_half[15] & ~r_unsigned}}, w_half};
         default: w_load = mem_rdata;
      endcase

      w_merged = mem_rdata;
      if (r_size == 2'b00) begin
         case (r_off)
            2'd0:    w_merged[7:0]   = r_wdata[7:0];
            2'd1:    w_merged[15:8]  = r_wdata[7:0];
            2'd2:    w_merged[23:16] = r_wdata[7:0];
            default: w_merged[31:24] = r_wdata[7:0];
         endcase
      end else if (r_off[1]) begin
         w_merged[31:16] = r_wdata;
      end else begin
         w_merged[15:0] = r_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_off      <= 2'b00;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_we       <= 1'b0;
         r_wdata    <= 16'h0000;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_data  <= 32'h0000_0000;
         resp_rd    <= '0;
         resp_err   <= 1'b0;
         mem_addr   <= 32'h0000_0000;
         mem_wdata  <= 32'h0000_0000;
         mem_we     <= 1'b0;
      end else begin
         // Write enable is a one-cycle pulse; only the transition into WR
         // raises it.
         mem_we <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_off      <= req_addr[1:0];
                  r_size     <= req_size;
                  r_unsigned <= req_unsigned;
                  r_we       <= req_we;
                  r_wdata    <= req_wdata[15:0];
                  resp_rd    <= req_rd;
                  resp_data  <= 32'h0000_0000;
                  req_ready  <= 1'b0;
                  if (w_err) begin
                     resp_err   <= 1'b1;
                     resp_valid <= 1'b1;
                     r_state    <= S_RESP;
                  end else begin
                     resp_err <= 1'b0;
                     mem_addr <= {2'b00, req_addr[31:2]};
                     if (req_we && (req_size == 2'b10)) begin
                        mem_wdata <= req_wdata;
                        mem_we    <= 1'b1;
                        r_state   <= S_WR;
                     end else begin
                        r_state <= S_RD;
                     end
                  end
               end
            end
            S_RD: begin
               // Memory samples mem_addr on this edge; data is valid in CAP.
               r_state <= S_CAP;
            end
            S_CAP: begin
               if (r_we) begin
                  mem_wdata <= w_merged;
                  mem_we    <= 1'b1;
                  r_state   <= S_WR;
               end else begin
                  resp_data  <= w_load;
                  resp_valid <= 1'b1;
                  r_state    <= S_RESP;
               end
            end
            S_WR: begin
               resp_valid <= 1'b1;
               r_state    <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  r_state    <= S_IDLE;
               end
            end
            default: begin
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Self-checking bench for load_store_unit. A word memory with a
//             registered read stands in for memory_stage; expected results
//             come from a byte-array model of memory and the access rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [4:0]  req_rd = 5'd0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   int n_pass  = 0;
   int n_total = 0;

   load_store_unit #(.DEPTH_WORDS(1024), .RD_W(5)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_rd(req_rd),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_rd(resp_rd), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Word memory with registered read; a side port preloads contents.
   logic [31:0] mem [0:1023];
   logic        poke_en = 1'b0;
   logic [9:0]  poke_idx = 10'd0;
   logic [31:0] poke_val = 32'h0;
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
      else if (poke_en) mem[poke_idx] <= poke_val;
      mem_rdata <= mem[mem_addr[9:0]];
   end

   // Write monitor
   int          we_cnt = 0;
   logic [31:0] we_addr_seen = 32'h0;
   logic [31:0] we_data_seen = 32'h0;
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         we_cnt++;
         we_addr_seen = mem_addr;
         we_data_seen = mem_wdata;
      end
   end

   // ---------------- reference model: memory as a byte array --------------
   logic [7:0] ref_mem [0:4095];

   function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
      logic e;
      e = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
          (size == 2'd2 && addr[1:0] != 2'd0);
`ifdef LSU_BOUNDS_CHECK_EN
      if ((addr >> 2) >= 32'd1024) e = 1'b1;
`endif
      return e;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                              input logic [31:0] addr);
      int     n;
      longint v;
      n = 1 << size;
      v = 0;
      for (int k = 0; k < n; k++)
         v = v | (longint'(ref_mem[int'(addr[11:0]) + k]) << (8 * k));
      if (!uns && v[8*n-1]) v = v - (longint'(1) << (8 * n));
      return v[31:0];
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] addr);
      int b;
      b = int'({addr[11:2], 2'b00});
      return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
   endfunction

   task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata);
      int n;
      n = 1 << size;
      for (int k = 0; k < n; k++)
         ref_mem[int'(addr[11:0]) + k] = wdata[8*k +: 8];
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic poke(input int idx, input logic [31:0] val);
      @(negedge clk);
      poke_en  = 1'b1;
      poke_idx = 10'(idx);
      poke_val = val;
      for (int k = 0; k < 4; k++) ref_mem[idx*4 + k] = val[8*k +: 8];
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input int hold);
      logic        err;
      int          exp_lat, lat, we0;
      logic [31:0] exp_data, exp_word;
      err      = model_err(size, addr);
      exp_data = 32'h0;
      exp_word = 32'h0;
      if (err) begin
         exp_lat = 1;
      end else if (we) begin
         model_store(size, addr, wdata);
         exp_word = model_word(addr);
         exp_lat  = (size == 2'd2) ? 2 : 4;
      end else begin
         exp_data = model_load(size, uns, addr);
         exp_lat  = 3;
      end

      @(negedge clk);
      chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
      we0          = we_cnt;
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      req_rd       = rd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("resp_data", resp_data, exp_data);
      chk("resp_err", {31'b0, resp_err}, {31'b0, err});
      chk("resp_rd", {27'b0, resp_rd}, {27'b0, rd});
      chk("we_pulses", 32'(we_cnt - we0), (!err && we) ? 32'd1 : 32'd0);
      if (!err && we) begin
         chk("we_addr", we_addr_seen, {2'b00, addr[31:2]});
         chk("we_data", we_data_seen, exp_word);
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", {31'b0, resp_valid}, 32'd1);
         chk("hold_data", resp_data, exp_data);
         chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
      end
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      chk("resp_drop", {31'b0, resp_valid}, 32'd0);
      chk("req_ready_back", {31'b0, req_ready}, 32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset state
      resp_ready = 1'b1;   // must be ignored outside RESP
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_rd", {27'b0, resp_rd}, 32'd0);
      chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      resp_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 1024; i++) poke(i, $urandom);

      // Word store then load
      run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 5'd3, 0);
      chk("sw_addr_const", we_addr_seen, 32'd4);
      run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd4, 0);

      // Signed / unsigned byte loads
      poke(4, 32'h80FF7F01);
      run_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 5'd5, 0);
      run_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 5'd6, 0);
      run_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 5'd7, 0);
      run_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 5'd8, 0);

      // Half store read-modify-write
      poke(4, 32'h11223344);
      run_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000AAAA, 5'd9, 0);
      chk("rmw_const", we_data_seen, 32'hAAAA3344);

      // Errors
      run_req(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 5'd10, 0);
      run_req(1'b1, 2'd1, 1'b0, 32'h11, 32'h1234, 5'd11, 0);
      run_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 5'd12, 0);
      run_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 5'd13, 0);

      // Backpressure, then an immediate follow-on request
      run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd14, 5);
      run_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 5'd15, 0);

      // Reset during WR of a byte store
      poke(8, 32'h55667788);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'h21; req_wdata = 32'hCC; req_rd = 5'd16;
      @(posedge clk); #1; req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rmw_in_wr", {31'b0, mem_we}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_we", {31'b0, mem_we}, 32'd0);
      chk("rst_mid_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("no_resp_after_rst", {31'b0, resp_valid}, 32'd0);
      end
      run_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 5'd17, 0);

      // Randomized traffic
      for (int t = 0; t < 80; t++) begin
         logic [31:0] a;
         a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 7) == 0) a = a | 32'h0000_1000 | (32'($urandom) & 32'hFFFF_0000);
         run_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
                 5'($urandom), int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
